// File: rtl/program_loader.sv
// program_loader: byte-stream loader that frames, checks and writes 12-bit
// instructions into instruction memory, holding the core until the frame
// completes and then releasing it at the frame's start address.
//
// Frame: 0xA5, ADDR, LEN, LEN x (HI, LO), [CHK]
// Optional build macro: LOADER_CHECKSUM_EN adds the trailing CHK byte, which
// must equal (ADDR + LEN + all HI + all LO) mod 256.
//
// Handshake: a byte moves only on a cycle where in_valid and in_ready are both
// high; in_ready is low only while reset is asserted, and a low in_valid simply
// stalls the FSM in its current state.
module program_loader #(
  parameter int WORD_RANGE        = 8,
  parameter int INST_RANGE        = 12,
  parameter int OP_CODE_RANGE     = 4,
  parameter int MEMORY_WORD_COUNT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_RANGE-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [WORD_RANGE-1:0] mem_addr,
  output logic [INST_RANGE-1:0] mem_data,
  output logic                  core_hold,
  output logic [WORD_RANGE-1:0] run_pc,
  output logic                  run_start,
  output logic                  busy,
  output logic                  error
);

  localparam logic [WORD_RANGE-1:0] SYNC_BYTE = WORD_RANGE'(8'hA5);
  localparam logic [WORD_RANGE-1:0] LAST_ADDR = WORD_RANGE'(MEMORY_WORD_COUNT - 1);
  localparam logic [WORD_RANGE-1:0] ONE       = WORD_RANGE'(1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_LEN  = 3'd2,
    GET_HI   = 3'd3,
    GET_LO   = 3'd4,
    GET_CHK  = 3'd5,
    DONE     = 3'd6,
    ERROR    = 3'd7
  } state_t;
  // After the last payload word the checksum byte is still outstanding.
  localparam state_t AFTER_LAST = GET_CHK;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_LEN  = 3'd2,
    GET_HI   = 3'd3,
    GET_LO   = 3'd4,
    DONE     = 3'd6,
    ERROR    = 3'd7
  } state_t;
  // Without checksums the frame ends with the last payload word.
  localparam state_t AFTER_LAST = DONE;
`endif

  state_t state;
  state_t state_next;

  logic                     fire;
  logic                     is_sync;
  logic                     hi_bad;
  logic                     last_word;
  logic [WORD_RANGE-1:0]    ptr;
  logic [WORD_RANGE-1:0]    count;
  logic [OP_CODE_RANGE-1:0] nibble;
`ifdef LOADER_CHECKSUM_EN
  logic [WORD_RANGE-1:0]    sum;
`endif

  assign in_ready  = ~reset;
  assign fire      = in_valid & in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  // Only the low nibble of HI belongs to the instruction; anything above it is malformed.
  assign hi_bad    = |in_data[WORD_RANGE-1:OP_CODE_RANGE];
  assign last_word = (count == ONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    core_hold  = 1'b0;
    busy       = 1'b0;
    error      = 1'b0;
    run_start  = 1'b0;
    case (state)
      IDLE: begin
        if (fire && is_sync) state_next = GET_ADDR;
      end
      GET_ADDR: begin
        core_hold = 1'b1;
        busy      = 1'b1;
        if (fire) state_next = GET_LEN;
      end
      GET_LEN: begin
        core_hold = 1'b1;
        busy      = 1'b1;
        if (fire) state_next = (in_data == '0) ? AFTER_LAST : GET_HI;
      end
      GET_HI: begin
        core_hold = 1'b1;
        busy      = 1'b1;
        if (fire) state_next = hi_bad ? ERROR : GET_LO;
      end
      GET_LO: begin
        core_hold = 1'b1;
        busy      = 1'b1;
        if (fire) state_next = last_word ? AFTER_LAST : GET_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      GET_CHK: begin
        core_hold = 1'b1;
        busy      = 1'b1;
        if (fire) state_next = (in_data == sum) ? DONE : ERROR;
      end
`endif
      DONE: begin
        run_start  = 1'b1;
        state_next = IDLE;
      end
      ERROR: begin
        // The core stays held: memory may contain a partial frame.
        core_hold = 1'b1;
        error     = 1'b1;
        if (fire && is_sync) state_next = GET_ADDR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: pointer, count, nibble, run_pc and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      count    <= '0;
      nibble   <= '0;
      run_pc   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we <= 1'b0;
      if (fire) begin
        case (state)
          GET_ADDR: begin
            ptr    <= in_data;
            run_pc <= in_data;
          end
          GET_LEN: count  <= in_data;
          GET_HI:  nibble <= in_data[OP_CODE_RANGE-1:0];
          GET_LO: begin
            mem_we   <= 1'b1;
            mem_addr <= ptr;
            mem_data <= {nibble, in_data};
            ptr      <= (ptr == LAST_ADDR) ? '0 : ptr + ONE;
            count    <= count - ONE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running checksum over every byte after the sync byte, restarted at each sync.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
    end else if (fire) begin
      case (state)
        IDLE, ERROR:                    if (is_sync) sum <= '0;
        GET_ADDR, GET_LEN, GET_HI, GET_LO: sum <= sum + in_data;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames against program_loader with a write
// scoreboard; follows LOADER_CHECKSUM_EN to decide whether CHK bytes are sent.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [11:0] mem_data;
  logic       core_hold;
  logic [7:0] run_pc;
  logic       run_start;
  logic       busy;
  logic       error;

  int total = 0;
  int bad   = 0;
  int we_count    = 0;
  int start_count = 0;
  int wb;
  int sb;
  logic [7:0]  last_pc    = 8'h00;
  logic        prev_we    = 1'b0;
  logic        prev_start = 1'b0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_w;

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .core_hold (core_hold),
    .run_pc    (run_pc),
    .run_start (run_start),
    .busy      (busy),
    .error     (error)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: one byte, accepted at the next rising edge with in_ready high.
  task automatic send_byte(input logic [7:0] b);
    int tries;
    tries = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    if (tries == 8) begin
      total++;
      bad++;
      $error("FAIL ready_wait: in_ready got %b expected 1 within 8 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Driver: one idle cycle with a sync byte on the bus but in_valid low.
  task automatic gap();
    @(negedge clk);
    in_data  = 8'hA5;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready",  32'(in_ready),  0);
    check("rst_mem_we",    32'(mem_we),    0);
    check("rst_mem_addr",  32'(mem_addr),  0);
    check("rst_mem_data",  32'(mem_data),  0);
    check("rst_core_hold", 32'(core_hold), 0);
    check("rst_run_pc",    32'(run_pc),    0);
    check("rst_run_start", 32'(run_start), 0);
    check("rst_busy",      32'(busy),      0);
    check("rst_error",     32'(error),     0);
    check("rst_state",     32'(dut.state), 0);
  endtask

  // Scoreboard: every write strobe must match the head of exp_q; pulses must be single-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_count++;
      check("we_single", 32'(prev_we), 0);
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL we_unexpected: got write %h=%h expected no write", mem_addr, mem_data);
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("we_word", {12'h0, mem_addr, mem_data}, {12'h0, exp_w});
      end
    end
    if (run_start === 1'b1) begin
      start_count++;
      last_pc = run_pc;
      check("start_single", 32'(prev_start), 0);
    end
    prev_we    = mem_we;
    prev_start = run_start;
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(in_ready), 1);

    // Basic two-word frame at 0x10.
    wb = we_count; sb = start_count;
    exp_q.push_back({8'h10, 12'h03D});
    exp_q.push_back({8'h11, 12'h200});
    send_byte(8'hA5);
    check("f1_hold_sync", 32'(core_hold), 1);
    check("f1_busy_sync", 32'(busy), 1);
    check("f1_error_sync", 32'(error), 0);
    send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h3D);
    send_byte(8'h02); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h51);
`endif
    idle(3);
    check("f1_writes", 32'(we_count - wb), 2);
    check("f1_starts", 32'(start_count - sb), 1);
    check("f1_start_pc", 32'(last_pc), 32'h10);
    check("f1_run_pc_hold", 32'(run_pc), 32'h10);
    check("f1_hold_done", 32'(core_hold), 0);
    check("f1_busy_done", 32'(busy), 0);
    check("f1_drained", 32'(exp_q.size()), 0);

`ifdef LOADER_CHECKSUM_EN
    // Same frame with a wrong checksum: words stay written, core stays held.
    wb = we_count; sb = start_count;
    exp_q.push_back({8'h10, 12'h03D});
    exp_q.push_back({8'h11, 12'h200});
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h3D); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h52);
    idle(3);
    check("chk_bad_writes", 32'(we_count - wb), 2);
    check("chk_bad_error", 32'(error), 1);
    check("chk_bad_hold", 32'(core_hold), 1);
    check("chk_bad_busy", 32'(busy), 0);
    check("chk_bad_starts", 32'(start_count - sb), 0);
    // Good frame recovers.
    wb = we_count; sb = start_count;
    exp_q.push_back({8'h10, 12'h03D});
    exp_q.push_back({8'h11, 12'h200});
    send_byte(8'hA5);
    check("chk_recover_error", 32'(error), 0);
    send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h3D); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h51);
    idle(3);
    check("chk_good_writes", 32'(we_count - wb), 2);
    check("chk_good_starts", 32'(start_count - sb), 1);
    check("chk_good_hold", 32'(core_hold), 0);
`endif

    // Bad HI byte: error immediately, nothing written, later bytes ignored.
    wb = we_count; sb = start_count;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'hF0);
    check("hi_bad_error", 32'(error), 1);
    check("hi_bad_hold", 32'(core_hold), 1);
    check("hi_bad_busy", 32'(busy), 0);
    send_byte(8'h3D);
    idle(2);
    check("hi_bad_writes", 32'(we_count - wb), 0);
    check("hi_bad_error_after", 32'(error), 1);
    check("hi_bad_starts", 32'(start_count - sb), 0);

    // Address wrap 0xFF -> 0x00, also restarting out of ERROR.
    wb = we_count; sb = start_count;
    exp_q.push_back({8'hFF, 12'h001});
    exp_q.push_back({8'h00, 12'h002});
    send_byte(8'hA5);
    check("wrap_error_cleared", 32'(error), 0);
    check("wrap_busy", 32'(busy), 1);
    send_byte(8'hFF); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h02);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h04);
`endif
    idle(3);
    check("wrap_writes", 32'(we_count - wb), 2);
    check("wrap_starts", 32'(start_count - sb), 1);
    check("wrap_start_pc", 32'(last_pc), 32'hFF);
    check("wrap_drained", 32'(exp_q.size()), 0);

    // Garbage then an empty frame, with an invalid cycle after every byte.
    wb = we_count; sb = start_count;
    send_byte(8'h11); gap();
    send_byte(8'h22); gap();
    send_byte(8'hA5); gap();
    send_byte(8'h05); gap();
    send_byte(8'h00); gap();
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h05); gap();
`endif
    idle(3);
    check("gap_writes", 32'(we_count - wb), 0);
    check("gap_starts", 32'(start_count - sb), 1);
    check("gap_start_pc", 32'(last_pc), 32'h05);
    check("gap_hold", 32'(core_hold), 0);
    check("gap_state", 32'(dut.state), 0);

    // Reset in the middle of a frame after one word has been written.
    exp_q.push_back({8'h07, 12'h001});
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h03);
    send_byte(8'h00); send_byte(8'h01);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    check("mid_rst_drained", 32'(exp_q.size()), 0);
    wb = we_count; sb = start_count;
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h02); send_byte(8'h00);
    idle(3);
    check("post_rst_writes", 32'(we_count - wb), 0);
    check("post_rst_starts", 32'(start_count - sb), 0);
    check("post_rst_hold", 32'(core_hold), 0);
    check("post_rst_state", 32'(dut.state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
